cond_unit: RTL

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/cond_unit_if.sv | 34 +++
 rtl/cond_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/cond_unit_if.sv
// Decode/execute handshake bundle for the condition unit.
// master = pipeline control driving decode fields, slave = cond_unit.
interface cond_unit_if;
    logic [3:0] CondD;
    logic [1:0] FlagWD;
    logic       PCSD;
    logic       RegWD;
    logic       MemWD;
    logic       BranchD;
    logic       NoWriteD;
    logic [3:0] ALUFlags;
    logic       StallE;
    logic       FlushE;

    logic       PCSrcE;
    logic       RegWriteE;
    logic       MemWriteE;
    logic       BranchTakenE;
    logic       CondExE;
    logic [3:0] Flags;
    logic       ValidE;

    modport master (
        output CondD, FlagWD, PCSD, RegWD, MemWD, BranchD, NoWriteD,
        output ALUFlags, StallE, FlushE,
        input  PCSrcE, RegWriteE, MemWriteE, BranchTakenE, CondExE, Flags, ValidE
    );

    modport slave (
        input  CondD, FlagWD, PCSD, RegWD, MemWD, BranchD, NoWriteD,
        input  ALUFlags, StallE, FlushE,
        output PCSrcE, RegWriteE, MemWriteE, BranchTakenE, CondExE, Flags, ValidE
    );
endinterface

// File: rtl/cond_unit.sv
// Purpose: D->E control register plus condition check and NZCV flag register.
// Latency: controls captured at edge N qualify combinationally in cycle N+1.
// Backpressure: StallE holds the E entry and blocks flag writes; FlushE (wins) inserts a bubble.
module cond_unit (
    input  logic        clk,
    input  logic        reset,
    cond_unit_if.slave  bus
);

    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] flag_we;
        logic       pcs;
        logic       reg_we;
        logic       mem_we;
        logic       branch;
        logic       no_write;
    } ctrl_t;

    ctrl_t      ctrl_d;
    ctrl_t      ctrl_e;
    logic       valid_e;
    logic [3:0] flags_q;
    logic       cond_pass;
    logic       cond_ex;
    logic       wr_nz;
    logic       wr_cv;

    function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic res;
        {n, z, c, v} = nzcv;
        res = 1'b0;
        case (cond)
            4'b0000: res = z;
            4'b0001: res = ~z;
            4'b0010: res = c;
            4'b0011: res = ~c;
            4'b0100: res = n;
            4'b0101: res = ~n;
            4'b0110: res = v;
            4'b0111: res = ~v;
            4'b1000: res = c & ~z;
            4'b1001: res = ~c | z;
            4'b1010: res = (n == v);
            4'b1011: res = (n != v);
            4'b1100: res = ~z & (n == v);
            4'b1101: res = z | (n != v);
            4'b1110: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    always_comb begin
        ctrl_d          = '0;
        ctrl_d.cond     = bus.CondD;
        ctrl_d.flag_we  = bus.FlagWD;
        ctrl_d.pcs      = bus.PCSD;
        ctrl_d.reg_we   = bus.RegWD;
        ctrl_d.mem_we   = bus.MemWD;
        ctrl_d.branch   = bus.BranchD;
        ctrl_d.no_write = bus.NoWriteD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_e  <= '0;
            valid_e <= 1'b0;
        end else if (bus.FlushE) begin
            ctrl_e  <= '0;
            valid_e <= 1'b0;
        end else if (!bus.StallE) begin
            ctrl_e  <= ctrl_d;
            valid_e <= 1'b1;
        end
    end

    assign cond_pass = eval_cond(ctrl_e.cond, flags_q);
    assign cond_ex   = valid_e & cond_pass;

    // Stall gating keeps a held instruction from writing flags more than once.
    assign wr_nz = cond_ex & ctrl_e.flag_we[1] & ~bus.StallE;
    assign wr_cv = cond_ex & ctrl_e.flag_we[0] & ~bus.StallE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else begin
            if (wr_nz) flags_q[3:2] <= bus.ALUFlags[3:2];
            if (wr_cv) flags_q[1:0] <= bus.ALUFlags[1:0];
        end
    end

    assign bus.CondExE      = cond_ex;
    assign bus.RegWriteE    = cond_ex & ctrl_e.reg_we & ~ctrl_e.no_write;
    assign bus.MemWriteE    = cond_ex & ctrl_e.mem_we;
    assign bus.PCSrcE       = cond_ex & ctrl_e.pcs;
    assign bus.BranchTakenE = cond_ex & ctrl_e.branch;
    assign bus.Flags        = flags_q;
    assign bus.ValidE       = valid_e;

endmodule
